// File: rtl/ahb_apb3_bridge_mux.sv
// ----------------------------------------------------------------------------
// ahb_apb3_bridge_mux
//
// AHB-Lite slave to APB3 master bridge that fans out to up to 16 APB slots.
// One AHB transfer is converted into one APB transfer on the slot chosen by
// HADDR[SLOT_LSB+3:SLOT_LSB]. If that index has no slot behind it, the bridge
// answers with a two-cycle AHB ERROR response. An optional wait-state timeout
// aborts an APB access whose slave never raises PREADY.
//
// Parameters:
//   ADDR_W    address width (12..32)
//   DATA_W    data width (32 or 64)
//   NUM_SLOTS number of APB slots (1..16)
//   SLOT_LSB  lowest HADDR bit of the 4-bit slot index
//   TIMEOUT   max ACCESS cycles before abort, 0 disables the timeout
//
// Ports:
//   HCLK, HRESET       clock (rising edge), synchronous active-high reset
//   HSEL, HREADY,      AHB-Lite address-phase controls
//   HWRITE, HTRANS,
//   HADDR
//   HWDATA             AHB write data, sampled in the data phase
//   HRDATA             registered read data
//   HREADYOUT, HRESP   transfer done / response (00 OKAY, 01 ERROR)
//   PADDR, PWRITE,     registered APB address, direction and write data
//   PWDATA
//   PSEL, PENABLE      one-hot APB select and enable
//   PRDATA, PREADY,    per-slot APB returns; slot k read data occupies
//   PSLVERR            PRDATA[k*DATA_W +: DATA_W]
// ----------------------------------------------------------------------------
module ahb_apb3_bridge_mux #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_LSB  = 12,
    parameter int TIMEOUT   = 256
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        HSEL,
    input  logic                        HREADY,
    input  logic                        HWRITE,
    input  logic [1:0]                  HTRANS,
    input  logic [ADDR_W-1:0]           HADDR,
    input  logic [DATA_W-1:0]           HWDATA,
    output logic [DATA_W-1:0]           HRDATA,
    output logic                        HREADYOUT,
    output logic [1:0]                  HRESP,
    output logic [ADDR_W-1:0]           PADDR,
    output logic [NUM_SLOTS-1:0]        PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [DATA_W-1:0]           PWDATA,
    input  logic [NUM_SLOTS*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLOTS-1:0]        PREADY,
    input  logic [NUM_SLOTS-1:0]        PSLVERR
);

    // With TIMEOUT = 0 the counter is still kept (1 bit wide) so the logic
    // below stays uniform; it simply never triggers an abort.
    localparam int              CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = TIMEOUT_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [4:0]      SLOT_COUNT = 5'(NUM_SLOTS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                 state_q,     state_d;
    logic [3:0]             slot_q,      slot_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [DATA_W-1:0]      hrdata_q,    hrdata_d;
    logic                   hreadyout_q, hreadyout_d;
    logic [1:0]             hresp_q,     hresp_d;
    logic [ADDR_W-1:0]      paddr_q,     paddr_d;
    logic [NUM_SLOTS-1:0]   psel_q,      psel_d;
    logic                   penable_q,   penable_d;
    logic                   pwrite_q,    pwrite_d;
    logic [DATA_W-1:0]      pwdata_q,    pwdata_d;

    logic                   accept;
    logic [3:0]             slot_in;
    logic                   slot_unmapped;
    logic                   sel_ready;
    logic                   sel_err;
    logic [DATA_W-1:0]      sel_rdata;

    // HTRANS[0] only separates SEQ from NONSEQ, which the bridge treats alike.
    logic                   unused_htrans;
    assign unused_htrans = HTRANS[0];

    // A transfer is only taken while the bridge itself reports ready, which
    // happens in IDLE and ERR2 only.
    assign accept        = HSEL & HREADY & HTRANS[1] & hreadyout_q;
    assign slot_in       = HADDR[SLOT_LSB+3:SLOT_LSB];
    assign slot_unmapped = ({1'b0, slot_in} >= SLOT_COUNT);

    // Return-path mux, steered by the registered slot index. An index with
    // no slot behind it never reaches ACCESS, so the zero default is unused
    // in practice.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_q == 4'(k)) begin
                sel_ready = PREADY[k];
                sel_err   = PSLVERR[k];
                sel_rdata = PRDATA[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output computation. All bus outputs are derived
    // from the state being entered so they appear registered in that state.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        cnt_d    = cnt_q;
        hrdata_d = hrdata_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;

        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    paddr_d  = HADDR;
                    pwrite_d = HWRITE;
                    slot_d   = slot_in;
                    if (slot_unmapped) begin
                        state_d = ST_ERR1;
                    end else if (HWRITE) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end

            ST_WDATA: begin
                pwdata_d = HWDATA;
                state_d  = ST_SETUP;
            end

            ST_SETUP: begin
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (sel_ready) begin
                    if (sel_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_IDLE;
                        if (!pwrite_q) begin
                            hrdata_d = sel_rdata;
                        end
                    end
                end else begin
                    // Saturating wait counter; the abort fires on the
                    // TIMEOUT-th ACCESS cycle that still sees PREADY low.
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                        state_d = ST_ERR1;
                    end
                end
            end

            ST_ERR1: begin
                state_d = ST_ERR2;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_SETUP) begin
            cnt_d = '0;
        end

        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? 2'b01 : 2'b00;
        penable_d   = (state_d == ST_ACCESS);

        psel_d = '0;
        if ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                psel_d[k] = (slot_d == 4'(k));
            end
        end
    end

    // Single register stage for the state machine and every bus output.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            cnt_q       <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'b00;
            paddr_q     <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb_apb3_bridge_mux.sv
// ----------------------------------------------------------------------------
// tb_ahb_apb3_bridge_mux
//
// Self-checking bench for ahb_apb3_bridge_mux (4 slots, 32-bit, TIMEOUT = 8).
// Each AHB transfer pushes its predicted completion (latency, response and
// read data) into a scoreboard queue; the entry is popped and compared when
// the bridge raises HREADYOUT. The APB slot behaviour (wait states, error,
// read data) is played by the bench while the transfer runs, and the APB
// handshake is checked cycle by cycle against a small timing model.
// ----------------------------------------------------------------------------
module tb_ahb_apb3_bridge_mux;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int NUM_SLOTS  = 4;
    localparam int SLOT_LSB   = 12;
    localparam int TIMEOUT    = 8;
    localparam int MAX_CYCLES = 40;

    logic                        HCLK = 1'b0;
    logic                        HRESET = 1'b1;
    logic                        HSEL = 1'b0;
    logic                        HREADY = 1'b1;
    logic                        HWRITE = 1'b0;
    logic [1:0]                  HTRANS = 2'b00;
    logic [ADDR_W-1:0]           HADDR = '0;
    logic [DATA_W-1:0]           HWDATA = '0;
    logic [DATA_W-1:0]           HRDATA;
    logic                        HREADYOUT;
    logic [1:0]                  HRESP;
    logic [ADDR_W-1:0]           PADDR;
    logic [NUM_SLOTS-1:0]        PSEL;
    logic                        PENABLE;
    logic                        PWRITE;
    logic [DATA_W-1:0]           PWDATA;
    logic [NUM_SLOTS*DATA_W-1:0] PRDATA = '0;
    logic [NUM_SLOTS-1:0]        PREADY = '0;
    logic [NUM_SLOTS-1:0]        PSLVERR = '0;

    typedef struct {
        int          lat;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } expect_t;

    expect_t     scoreboard[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] modelHrdata = '0;
    logic [31:0] modelPwdata = '0;
    logic [31:0] modelPaddr = '0;
    logic        modelPwrite = 1'b0;

    ahb_apb3_bridge_mux #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_LSB  (SLOT_LSB),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the test sequence ended");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_hreadyout"}, HREADYOUT, 1'b1);
        checkOutput({tag, "_hresp"},     HRESP,     2'b00);
        checkOutput({tag, "_hrdata"},    HRDATA,    32'h0);
        checkOutput({tag, "_psel"},      PSEL,      4'b0);
        checkOutput({tag, "_penable"},   PENABLE,   1'b0);
        checkOutput({tag, "_paddr"},     PADDR,     32'h0);
        checkOutput({tag, "_pwrite"},    PWRITE,    1'b0);
        checkOutput({tag, "_pwdata"},    PWDATA,    32'h0);
    endtask

    // Offers a transfer that must not be accepted and checks the bridge stays
    // idle with its APB-side registers unchanged.
    task automatic applyIdle(input logic hsel, input logic [1:0] htrans, input logic hready);
        HSEL   = hsel;
        HTRANS = htrans;
        HREADY = hready;
        HWRITE = 1'b1;
        HADDR  = 32'hABCD_0040;
        @(negedge HCLK);
        checkOutput("noaccept_psel",   PSEL,      4'b0);
        checkOutput("noaccept_hready", HREADYOUT, 1'b1);
        checkOutput("hold_paddr",      PADDR,     modelPaddr);
        checkOutput("hold_pwrite",     PWRITE,    modelPwrite);
        checkOutput("hold_pwdata",     PWDATA,    modelPwdata);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HREADY = 1'b1;
    endtask

    // Runs one AHB transfer; called at a negedge where HREADYOUT is high.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int waits, input logic slverr, input logic [31:0] rdata);
        int      slot, a, s, e, lat, n, accCnt;
        logic    unmapped, isErr;
        logic [3:0] onehot;
        expect_t expItem, got;

        slot     = int'(addr[15:12]);
        unmapped = (slot >= NUM_SLOTS);
        onehot   = unmapped ? 4'b0 : 4'(1 << slot);
        a        = wr ? 3 : 2;
        if (unmapped) begin
            s = 1; e = 0; lat = 2; isErr = 1'b1;
        end else begin
            s = a - 1;
            if (waits >= TIMEOUT) begin
                e = a + TIMEOUT - 1; lat = e + 2; isErr = 1'b1;
            end else begin
                e = a + waits; isErr = slverr; lat = slverr ? e + 2 : e + 1;
            end
        end
        expItem.lat   = lat;
        expItem.resp  = isErr ? 2'b01 : 2'b00;
        expItem.rdata = (!isErr && !wr) ? rdata : modelHrdata;
        scoreboard.push_back(expItem);

        HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HWDATA = ~wdata;
        PREADY = 4'b0; PSLVERR = 4'b0;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = $urandom; HWRITE = ~wr;
        n = 1;
        accCnt = 0;
        while (n <= MAX_CYCLES) begin
            checkOutput("psel",      PSEL,      (n >= s && n <= e) ? onehot : 4'b0);
            checkOutput("penable",   PENABLE,   (n >= a && n <= e && !unmapped));
            checkOutput("hreadyout", HREADYOUT, (n >= lat));
            checkOutput("hresp",     HRESP,     (isErr && n >= lat - 1) ? 2'b01 : 2'b00);
            if (n == 1) begin
                checkOutput("paddr",       PADDR,  addr);
                checkOutput("pwrite",      PWRITE, wr);
                checkOutput("hrdata_hold", HRDATA, modelHrdata);
                checkOutput("pwdata_hold", PWDATA, modelPwdata);
            end
            if (wr && !unmapped && n >= 2) begin
                checkOutput("pwdata", PWDATA, wdata);
            end
            if (HREADYOUT === 1'b1) break;

            // Data phase for the edge closing this cycle, then the slot reply.
            HWDATA  = (n == 1) ? wdata : ~wdata;
            PREADY  = 4'b1111;
            PSLVERR = 4'b1111;
            PRDATA  = {4{32'hBAD0_0BAD}};
            if (!unmapped) begin
                PREADY[slot]  = 1'b0;
                PSLVERR[slot] = 1'b0;
                if (PSEL[slot] === 1'b1 && PENABLE === 1'b1) begin
                    accCnt++;
                    if (accCnt > waits) begin
                        PREADY[slot]              = 1'b1;
                        PSLVERR[slot]             = slverr;
                        PRDATA[slot*32 +: 32]     = rdata;
                    end
                end
            end
            @(negedge HCLK);
            n++;
        end
        checkOutput("completed", HREADYOUT, 1'b1);

        got = scoreboard.pop_front();
        checkOutput("latency",     n,      got.lat);
        checkOutput("hresp_done",  HRESP,  got.resp);
        checkOutput("hrdata_done", HRDATA, got.rdata);

        modelHrdata = got.rdata;
        modelPaddr  = addr;
        modelPwrite = wr;
        if (wr && !unmapped) modelPwdata = wdata;
        PREADY  = 4'b0;
        PSLVERR = 4'b0;
    endtask

    initial begin
        int          slot, waits;
        logic        wr, slverr;
        logic [31:0] addr;

        $display("[TB] start");
        HRESET = 1'b1;
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        checkResetValues("reset");

        // Qualifiers that must each block an accept
        applyIdle(1'b1, 2'b00, 1'b1);
        applyIdle(1'b0, 2'b10, 1'b1);
        applyIdle(1'b1, 2'b10, 1'b0);

        // Directed transfers
        applyStimulus(1'b0, 32'h0000_2010, 32'h0, 0, 1'b0, 32'hCAFE_0001);
        applyStimulus(1'b1, 32'h0000_0004, 32'h1234_5678, 3, 1'b0, 32'h0);
        applyIdle(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b0, 32'h0000_5000, 32'h0, 0, 1'b0, 32'h1111_1111);
        applyStimulus(1'b0, 32'h0000_1020, 32'h0, 0, 1'b1, 32'h2222_2222);
        applyStimulus(1'b0, 32'h0000_3000, 32'h0, 8, 1'b0, 32'h3333_3333);
        applyStimulus(1'b0, 32'h0000_3004, 32'h0, 7, 1'b0, 32'h4444_4444);
        applyStimulus(1'b0, 32'h8000_1008, 32'h0, 2, 1'b0, 32'h5555_5555);
        applyStimulus(1'b1, 32'h0000_2FFC, 32'hA5A5_5A5A, 1, 1'b1, 32'h0);
        applyStimulus(1'b1, 32'h0000_F000, 32'h0BAD_F00D, 0, 1'b0, 32'h0);

        // Random mix, including unmapped slots and timeouts
        for (int i = 0; i < 10; i++) begin
            slot   = $urandom_range(0, 5);
            addr   = (32'(slot) << 12) | (32'($urandom_range(0, 1023)) << 2);
            waits  = $urandom_range(0, 9);
            wr     = 1'($urandom_range(0, 1));
            slverr = ($urandom_range(0, 3) == 0);
            applyStimulus(wr, addr, $urandom, waits, slverr, $urandom);
        end

        // Reset held for two cycles in the middle of an ACCESS
        HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_1100;
        PREADY = 4'b0; PSLVERR = 4'b0;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        checkOutput("pre_reset_penable", PENABLE, 1'b1);
        HRESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            checkResetValues("midreset");
        end
        HRESET = 1'b0;
        @(negedge HCLK);
        checkOutput("post_reset_hready", HREADYOUT, 1'b1);
        checkOutput("post_reset_psel",   PSEL,      4'b0);
        modelHrdata = '0;
        modelPwdata = '0;
        modelPaddr  = '0;
        modelPwrite = 1'b0;
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 1, 1'b0, 32'h600D_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_apb3_bridge_mux.md
# ahb_apb3_bridge_mux

AHB-Lite slave to APB3 master bridge that drives up to 16 APB3 peripheral slots, each with its own select, read-data, ready and error return. It is the parametrised successor of the fixed single-slot 32-bit bridge. It adds address/data width parameters, one-hot slot decode, an unmapped-address error and a programmable APB wait-state timeout. The block sits between the fabric AHB-Lite interconnect and the peripheral APB segment, in the HCLK domain.

## Interface
Parameters:
- ADDR_W, 32: AHB/APB address width (12..32).
- DATA_W, 32: data width, 32 or 64.
- NUM_SLOTS, 4: number of APB slots (1..16).
- SLOT_LSB, 12: lowest HADDR bit of the slot index; index = HADDR[SLOT_LSB+3:SLOT_LSB].
- TIMEOUT, 256: maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- HCLK  in  1  the only clock, rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL, HREADY, HWRITE  in  1  AHB-Lite address-phase controls.
- HTRANS  in  2  AHB transfer type; bit 1 set means NONSEQ/SEQ.
- HADDR  in  ADDR_W  AHB address.
- HWDATA  in  DATA_W  AHB write data, valid in the data phase.
- HRDATA  out  DATA_W  registered read data.
- HREADYOUT  out  1  transfer done / bridge ready.
- HRESP  out  2  00 = OKAY, 01 = ERROR.
- PADDR  out  ADDR_W  registered APB address.
- PSEL  out  NUM_SLOTS  one-hot APB select.
- PENABLE, PWRITE  out  1  APB controls.
- PWDATA  out  DATA_W  registered APB write data.
- PRDATA  in  NUM_SLOTS*DATA_W  per-slot read data; slot k occupies bits [k*DATA_W +: DATA_W].
- PREADY, PSLVERR  in  NUM_SLOTS  per-slot ready and error.

## Operation
- The bridge accepts an AHB transfer when HSEL & HREADY & HTRANS[1] & HREADYOUT. It captures HADDR[ADDR_W-1:0] into PADDR, HWRITE into PWRITE, and the slot index.
- States: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=00.
- On accept:
  - If slot index ≥ NUM_SLOTS, go to ERR1. No PSEL is asserted.
  - Otherwise a write goes to WDATA and a read goes to SETUP.
- WDATA: PWDATA <= HWDATA; next state is SETUP.
- SETUP: PSEL[slot]=1, PENABLE=0; next state is ACCESS.
- ACCESS: PSEL[slot]=1, PENABLE=1. The selected slot's PREADY, PSLVERR and PRDATA are muxed by the registered slot index. Exit on the first of:
  - PREADY=1 & PSLVERR=0: go to IDLE. HRDATA <= PRDATA[slot] for reads; it holds its previous value for writes.
  - PREADY=1 & PSLVERR=1: go to ERR1.
  - Wait counter reaches TIMEOUT-1 with PREADY=0 (TIMEOUT>0): go to ERR1. PSEL and PENABLE drop in the next cycle.
- ERR1: HREADYOUT=0, HRESP=01.
- ERR2: HREADYOUT=1, HRESP=01. A transfer offered in ERR2 is accepted exactly as in IDLE.
- The wait counter is clog2(TIMEOUT+1) bits wide. It clears on SETUP entry and increments each ACCESS cycle with PREADY=0. It saturates and never wraps.
- HREADYOUT=0 in WDATA, SETUP, ACCESS and ERR1.
- PSEL bits other than the current slot are always 0.
- PSEL and PENABLE are 0 in IDLE, WDATA, ERR1 and ERR2.
- PADDR, PWRITE and PWDATA hold their values between transfers.

## Timing
- Every output is registered.
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0. State resets to IDLE and the counter to 0.
- Reset asserted mid-transfer aborts it at the next edge with the outputs above. No error response is given.
- Accept occurs at edge T (end of the address-phase cycle).
- Read, zero-wait slot: SETUP in T+1, ACCESS in T+2, HREADYOUT=1 with valid HRDATA in T+3. That is 2 AHB wait states.
- Write, zero-wait slot: WDATA in T+1, SETUP in T+2, ACCESS in T+3, HREADYOUT=1 in T+4. That is 3 wait states.
- Each APB wait cycle (PREADY=0) adds one AHB wait state.
- Unmapped address: ERR1 in T+1, ERR2 in T+2.
- PSLVERR error: ERR1 is the cycle after the completing ACCESS cycle, and ERR2 follows it.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, then ERR1, then ERR2.

## Test plan
- Reset: hold HRESET for 2 cycles during an ACCESS -> all outputs at their reset values at the next edge, HREADYOUT=1.
- Read slot 2 at HADDR=0x0000_2010 with PREADY[2]=1 and PRDATA slot 2=0xCAFE_0001 -> PSEL=0100 in T+1..T+2, PENABLE only in T+2, HRDATA=0xCAFE_0001 with HREADYOUT=1 in T+3, HRESP=00.
- Write 0x1234_5678 to slot 0 with PREADY[0] low for 3 ACCESS cycles -> PWDATA=0x1234_5678 from T+2, PWRITE=1, HREADYOUT returns high in T+7.
- Unmapped address 0x0000_5000 with NUM_SLOTS=4 -> PSEL stays 0, HRESP=01 in T+1 and T+2, HREADYOUT 0 then 1.
- PSLVERR[1]=1 with PREADY[1]=1 on a read -> two-cycle ERROR response, and HRDATA keeps its previous value.
- TIMEOUT=8 with PREADY held at 0 -> 8 ACCESS cycles, PSEL and PENABLE drop, then the ERROR pair. A back-to-back read offered in ERR2 completes normally.
